// File: rtl/gcd_controller_if.sv
// gcd_controller_if: controller-side handshake and datapath control bundle
interface gcd_controller_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic             gt;
  logic             lt;
  logic             eq;
  logic             lda;
  logic             ldb;
  logic             sel1;
  logic             sel2;
  logic             sel_in;
  logic             busy;
  logic             done;
  logic             error;
  logic [CNT_W-1:0] iter_cnt;
  logic             result_ack;

  modport master (
    input  start, in_valid, gt, lt, eq, result_ack,
    output in_ready, lda, ldb, sel1, sel2, sel_in, busy, done, error, iter_cnt
  );

  modport slave (
    output start, in_valid, gt, lt, eq, result_ack,
    input  in_ready, lda, ldb, sel1, sel2, sel_in, busy, done, error, iter_cnt
  );
endinterface

// File: rtl/gcd_controller.sv
// gcd_controller: sequences the subtractive GCD datapath and reports result status
module gcd_controller #(
  parameter int          CNT_W    = 16,
  parameter int unsigned MAX_ITER = 2**CNT_W-1
) (
  input  logic            clk,
  input  logic            rst_n,
  gcd_controller_if.master bus
);
  localparam logic [CNT_W-1:0] LIM = MAX_ITER[CNT_W-1:0];

  typedef enum logic [2:0] {S_IDLE, S_LOAD_A, S_LOAD_B, S_CALC, S_DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] iter;
  logic             err;
  logic             loading;
  logic             run;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      iter  <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE:   if (bus.start) begin
                    state <= S_LOAD_A;
                    iter  <= '0;
                    err   <= 1'b0;
                  end
        S_LOAD_A: if (bus.in_valid) state <= S_LOAD_B;
        S_LOAD_B: if (bus.in_valid) state <= S_CALC;
        S_CALC:   if (bus.eq) state <= S_DONE;
                  else if (iter == LIM) begin
                    state <= S_DONE;
                    err   <= 1'b1;
                  end else iter <= iter + 1'b1;
        S_DONE:   if (bus.result_ack) state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // run: a subtraction step is taken this cycle (no equality, no timeout)
  assign loading      = (state == S_LOAD_A) || (state == S_LOAD_B);
  assign run          = (state == S_CALC) && !bus.eq && (iter != LIM);
  assign bus.in_ready = loading;
  assign bus.sel_in   = loading;
  assign bus.sel1     = run && !bus.gt && bus.lt;
  assign bus.sel2     = run && bus.gt;
  assign bus.lda      = ((state == S_LOAD_A) && bus.in_valid) || (run && bus.gt);
  assign bus.ldb      = ((state == S_LOAD_B) && bus.in_valid) || (run && !bus.gt && bus.lt);
  assign bus.busy     = state != S_IDLE;
  assign bus.done     = state == S_DONE;
  assign bus.error    = err && (state == S_DONE);
  assign bus.iter_cnt = iter;
endmodule

// File: tb/tb_gcd_controller.sv
// tb_gcd_controller: directed checks of the GCD controller against a behavioural datapath
module tb_gcd_controller;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gcd_controller_if #(.CNT_W(16)) b();
  gcd_controller_if #(.CNT_W(16)) s();

  gcd_controller #(.CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(b));
  gcd_controller #(.CNT_W(16), .MAX_ITER(16)) dut_s (.clk(clk), .rst_n(rst_n), .bus(s));

  logic [15:0] din_b = '0, ra_b = '0, rb_b = '0, bus_b;
  logic [15:0] din_s = '0, ra_s = '0, rb_s = '0, bus_s;

  assign bus_b = b.sel_in ? din_b : (b.sel1 ? rb_b : ra_b) - (b.sel2 ? rb_b : ra_b);
  assign bus_s = s.sel_in ? din_s : (s.sel1 ? rb_s : ra_s) - (s.sel2 ? rb_s : ra_s);
  assign b.gt = ra_b > rb_b;
  assign b.lt = ra_b < rb_b;
  assign b.eq = ra_b == rb_b;
  assign s.gt = ra_s > rb_s;
  assign s.lt = ra_s < rb_s;
  assign s.eq = ra_s == rb_s;

  always_ff @(posedge clk) begin
    if (b.lda) ra_b <= bus_b;
    if (b.ldb) rb_b <= bus_b;
    if (s.lda) ra_s <= bus_s;
    if (s.ldb) rb_s <= bus_s;
  end

  int tests = 0;
  int fails = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // leaves the bench one step past the third edge, i.e. in the first CALC cycle
  task automatic load_b(input logic [15:0] a, input logic [15:0] bb);
    b.start = 1'b1; b.in_valid = 1'b1; din_b = a;
    tick;
    b.start = 1'b0;
    tick;
    din_b = bb;
    tick;
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (!b.done && n < budget) begin
      tick;
      n++;
    end
  endtask

  task automatic ack_b(input string name);
    b.result_ack = 1'b1;
    tick;
    b.result_ack = 1'b0;
    tests++; if ({b.done, b.busy} !== 2'b00) begin fails++; $display("FAIL %s_ack done,busy=%b exp 00", name, {b.done, b.busy}); end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; b.start = 1'b1; b.in_valid = 1'b1;
    tick; tick;
    tests++; if ({b.busy, b.done, b.error, b.in_ready, b.lda, b.ldb, b.sel1, b.sel2, b.sel_in} !== 9'b0) begin fails++; $display("FAIL reset_outs got %b exp 0", {b.busy, b.done, b.error, b.in_ready, b.lda, b.ldb, b.sel1, b.sel2, b.sel_in}); end
    tests++; if (b.iter_cnt !== 16'd0) begin fails++; $display("FAIL reset_iter got %0d exp 0", b.iter_cnt); end
    b.start = 1'b0; b.in_valid = 1'b0;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_basic;
    b.start = 1'b1; b.in_valid = 1'b1; din_b = 16'd12;
    tick;
    b.start = 1'b0;
    tests++; if ({b.in_ready, b.sel_in, b.lda, b.ldb, b.busy} !== 5'b11101) begin fails++; $display("FAIL basic_c1 got %b exp 11101", {b.in_ready, b.sel_in, b.lda, b.ldb, b.busy}); end
    tick;
    din_b = 16'd8;
    tests++; if ({b.in_ready, b.sel_in, b.lda, b.ldb} !== 4'b1101) begin fails++; $display("FAIL basic_c2 got %b exp 1101", {b.in_ready, b.sel_in, b.lda, b.ldb}); end
    tick;
    tests++; if ({b.in_ready, b.lda, b.ldb, b.sel1, b.sel2, b.sel_in} !== 6'b010010) begin fails++; $display("FAIL basic_c3 got %b exp 010010", {b.in_ready, b.lda, b.ldb, b.sel1, b.sel2, b.sel_in}); end
    tick;
    tests++; if ({b.lda, b.ldb, b.sel1, b.sel2, b.sel_in, ra_b} !== {5'b01100, 16'd4}) begin fails++; $display("FAIL basic_c4 got %b/%0d exp 01100/4", {b.lda, b.ldb, b.sel1, b.sel2, b.sel_in}, ra_b); end
    tick;
    tests++; if ({b.eq, b.lda, b.ldb, b.done} !== 4'b1000) begin fails++; $display("FAIL basic_c5 got %b exp 1000", {b.eq, b.lda, b.ldb, b.done}); end
    tick;
    tests++; if ({b.done, b.error, b.busy, b.iter_cnt} !== {3'b101, 16'd2}) begin fails++; $display("FAIL basic_c6 done,err,busy=%b iter=%0d exp 101/2", {b.done, b.error, b.busy}, b.iter_cnt); end
    tests++; if ({ra_b, rb_b} !== {16'd4, 16'd4}) begin fails++; $display("FAIL basic_regs got %0d,%0d exp 4,4", ra_b, rb_b); end
    ack_b("basic");
  endtask

  task automatic test_equal_and_long;
    int n;
    load_b(16'd7, 16'd7);
    wait_done(10, n);
    tests++; if ({b.done, b.error, b.iter_cnt} !== {2'b10, 16'd0} || n != 1) begin fails++; $display("FAIL equal got done,err=%b iter=%0d lat=%0d exp 10/0/1", {b.done, b.error}, b.iter_cnt, n); end
    ack_b("equal");
    load_b(16'd1, 16'd65535);
    wait_done(70000, n);
    tests++; if ({b.done, b.error, b.iter_cnt} !== {2'b10, 16'd65534}) begin fails++; $display("FAIL long got done,err=%b iter=%0d exp 10/65534", {b.done, b.error}, b.iter_cnt); end
    tests++; if ({ra_b, rb_b} !== {16'd1, 16'd1}) begin fails++; $display("FAIL long_regs got %0d,%0d exp 1,1", ra_b, rb_b); end
    ack_b("long");
  endtask

  task automatic test_timeout(input logic [15:0] a, input logic [15:0] bb, input int exp_a, input int exp_b);
    int na = 0, nb = 0, n = 0;
    s.start = 1'b1; s.in_valid = 1'b1; din_s = a;
    tick;
    s.start = 1'b0;
    tick;
    din_s = bb;
    tick;
    while (!s.done && n < 100) begin
      na += int'(s.lda);
      nb += int'(s.ldb);
      tick;
      n++;
    end
    tests++; if (na != exp_a || nb != exp_b) begin fails++; $display("FAIL timeout_pulses lda=%0d ldb=%0d exp %0d,%0d", na, nb, exp_a, exp_b); end
    tests++; if ({s.done, s.error, s.iter_cnt} !== {2'b11, 16'd16}) begin fails++; $display("FAIL timeout_result done,err=%b iter=%0d exp 11/16", {s.done, s.error}, s.iter_cnt); end
    s.result_ack = 1'b1;
    tick;
    s.result_ack = 1'b0;
    tests++; if ({s.done, s.error, s.busy} !== 3'b000) begin fails++; $display("FAIL timeout_ack got %b exp 000", {s.done, s.error, s.busy}); end
  endtask

  task automatic test_valid_gaps;
    int n, bad = 0;
    b.start = 1'b1; b.in_valid = 1'b0;
    tick;
    b.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din_b = 16'hdead ^ 16'(i);
      #1 bad += int'(b.lda || b.ldb || !b.in_ready);
      tick;
    end
    b.in_valid = 1'b1; din_b = 16'd21;
    tick;
    b.in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      din_b = 16'hbeef ^ 16'(i);
      #1 bad += int'(b.lda || b.ldb || !b.in_ready);
      tick;
    end
    tests++; if (bad != 0 || ra_b !== 16'd21) begin fails++; $display("FAIL gaps_hold bad=%0d A=%0d exp 0,21", bad, ra_b); end
    b.in_valid = 1'b1; din_b = 16'd14;
    tick;
    b.in_valid = 1'b0;
    wait_done(20, n);
    tests++; if ({b.done, b.error, b.iter_cnt, ra_b, rb_b} !== {2'b10, 16'd2, 16'd7, 16'd7}) begin fails++; $display("FAIL gaps_result done,err=%b iter=%0d A=%0d B=%0d exp 10/2/7/7", {b.done, b.error}, b.iter_cnt, ra_b, rb_b); end
    ack_b("gaps");
  endtask

  task automatic test_back_to_back;
    int n, bad = 0;
    load_b(16'd12, 16'd8);
    b.start = 1'b1;
    wait_done(20, n);
    for (int i = 0; i < 10; i++) begin
      bad += int'({b.done, b.busy, b.iter_cnt} !== {2'b11, 16'd2});
      tick;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL hold_done bad_cycles=%0d exp 0", bad); end
    b.result_ack = 1'b1;
    tick;
    b.result_ack = 1'b0;
    tests++; if ({b.done, b.busy} !== 2'b00) begin fails++; $display("FAIL ack_with_start got %b exp 00", {b.done, b.busy}); end
    b.start = 1'b0;
    tick;
    tests++; if (b.busy !== 1'b0) begin fails++; $display("FAIL no_queue busy=%b exp 0", b.busy); end
    load_b(16'd5, 16'd5);
    tests++; if ({b.busy, b.iter_cnt} !== {1'b1, 16'd0}) begin fails++; $display("FAIL restart busy=%b iter=%0d exp 1/0", b.busy, b.iter_cnt); end
    wait_done(10, n);
    ack_b("restart");
  endtask

  task automatic test_abort;
    int n, seen = 0;
    load_b(16'd100, 16'd3);
    tick; tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    tests++; if ({b.busy, b.done, b.error, b.in_ready, b.lda, b.ldb, b.sel1, b.sel2, b.sel_in, b.iter_cnt} !== 25'b0) begin fails++; $display("FAIL abort_outs got %b iter=%0d exp 0", {b.busy, b.done, b.error, b.in_ready, b.lda, b.ldb, b.sel1, b.sel2, b.sel_in}, b.iter_cnt); end
    b.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      seen += int'(b.done || b.busy);
      tick;
    end
    tests++; if (seen != 0) begin fails++; $display("FAIL abort_idle active_cycles=%0d exp 0", seen); end
    load_b(16'd9, 16'd6);
    wait_done(20, n);
    tests++; if ({b.done, b.error, b.iter_cnt, ra_b} !== {2'b10, 16'd2, 16'd3}) begin fails++; $display("FAIL after_abort done,err=%b iter=%0d A=%0d exp 10/2/3", {b.done, b.error}, b.iter_cnt, ra_b); end
    ack_b("after_abort");
  endtask

  initial begin
    b.start = 1'b0; b.in_valid = 1'b0; b.result_ack = 1'b0;
    s.start = 1'b0; s.in_valid = 1'b0; s.result_ack = 1'b0;
    test_reset;
    test_basic;
    test_equal_and_long;
    test_timeout(16'd0, 16'd5, 0, 16);
    test_timeout(16'd5, 16'd0, 16, 0);
    test_valid_gaps;
    test_back_to_back;
    test_abort;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
